// File: rtl/lb_slot_ctrl_pkg.sv
// Shared widths, descriptor layout and tag-range helper for the load-balancer
// slot store.
package lb_slot_ctrl_pkg;

    localparam int DEF_CORE_COUNT = 8;
    localparam int DEF_SLOT_COUNT = 32;

    function automatic int calc_slot_width(input int slot_count);
        return $clog2(slot_count + 1);
    endfunction

    function automatic int calc_tag_width(input int slot_width);
        return (slot_width > 5) ? slot_width : 5;
    endfunction

    function automatic int calc_id_tag_width(input int core_id_width, input int tag_width);
        return core_id_width + tag_width;
    endfunction

    localparam int DEF_SLOT_WIDTH    = calc_slot_width(DEF_SLOT_COUNT);
    localparam int DEF_CORE_ID_WIDTH = $clog2(DEF_CORE_COUNT);
    localparam int DEF_TAG_WIDTH     = calc_tag_width(DEF_SLOT_WIDTH);

    // Descriptor layout: core index in the upper bits, zero-extended tag below.
    typedef struct packed {
        logic [DEF_CORE_ID_WIDTH-1:0] core;
        logic [DEF_TAG_WIDTH-1:0]     tag;
    } desc_t;

    // Tags are 1-based; 0 is reserved to mean "no slot".
    function automatic logic tag_in_range(input logic [31:0] tag, input int slot_count);
        return (tag != 32'd0) && (tag <= 32'(slot_count));
    endfunction

endpackage

// File: rtl/lb_slot_fifo.sv
// First-word-fallthrough tag FIFO for one core: head is visible combinationally,
// clear empties it at the next edge and overrides push/pop.
module lb_slot_fifo
    import lb_slot_ctrl_pkg::*;
#(
    parameter int SLOT_COUNT = DEF_SLOT_COUNT,
    parameter int SLOT_WIDTH = calc_slot_width(SLOT_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [SLOT_WIDTH-1:0] push_tag,
    input  logic                  pop,
    input  logic                  clear,
    output logic [SLOT_WIDTH-1:0] head,
    output logic [SLOT_WIDTH-1:0] count,
    output logic                  valid
);

    localparam int PTR_W = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1;
    localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(SLOT_COUNT - 1);
    localparam logic [SLOT_WIDTH-1:0] FULL_CNT = SLOT_WIDTH'(SLOT_COUNT);

    logic [SLOT_WIDTH-1:0] mem [SLOT_COUNT];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [SLOT_WIDTH-1:0] count_q, count_d;
    logic                  valid_q, valid_d;
    logic                  push_eff, pop_eff;

    assign push_eff = push && !clear && (count_q < FULL_CNT);
    assign pop_eff  = pop && !clear && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + SLOT_WIDTH'(push_eff) - SLOT_WIDTH'(pop_eff);
        if (push_eff)
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        if (pop_eff)
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Tag storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push_eff)
            mem[wr_ptr_q] <= push_tag;
    end

    assign head  = (count_q != '0) ? mem[rd_ptr_q] : '0;
    assign count = count_q;
    assign valid = valid_q;

endmodule

// File: rtl/lb_slot_ctrl.sv
// Per-core free-slot store feeding the load balancer: insert decode, pop
// arbitration between the inter-core and LB ports, error pulses, output packing.
module lb_slot_ctrl
    import lb_slot_ctrl_pkg::*;
#(
    parameter int CORE_COUNT    = DEF_CORE_COUNT,
    parameter int SLOT_COUNT    = DEF_SLOT_COUNT,
    parameter int SLOT_WIDTH    = calc_slot_width(SLOT_COUNT),
    parameter int CORE_ID_WIDTH = $clog2(CORE_COUNT),
    parameter int TAG_WIDTH     = calc_tag_width(SLOT_WIDTH),
    parameter int ID_TAG_WIDTH  = calc_id_tag_width(CORE_ID_WIDTH, TAG_WIDTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CORE_COUNT-1:0]            enabled_cores,
    input  logic [CORE_COUNT-1:0]            slots_flush,
    input  logic                             slot_ins_valid,
    input  logic [CORE_ID_WIDTH-1:0]         slot_ins_core,
    input  logic [SLOT_WIDTH-1:0]            slot_ins_tag,
    input  logic [CORE_ID_WIDTH-1:0]         selected_core,
    input  logic                             desc_pop,
    output logic [ID_TAG_WIDTH-1:0]          desc_data,
    input  logic                             ic_req_valid,
    input  logic [CORE_ID_WIDTH-1:0]         ic_req_core,
    output logic                             ic_req_ready,
    output logic [ID_TAG_WIDTH-1:0]          ic_desc_data,
    output logic [CORE_COUNT*SLOT_WIDTH-1:0] slot_counts,
    output logic [CORE_COUNT-1:0]            slot_valids,
    output logic [CORE_COUNT-1:0]            slot_busys,
    output logic [CORE_COUNT-1:0]            slot_ins_errs
);

    localparam logic [SLOT_WIDTH-1:0] FULL_CNT = SLOT_WIDTH'(SLOT_COUNT);

    logic [SLOT_WIDTH-1:0] fifo_head  [CORE_COUNT];
    logic [SLOT_WIDTH-1:0] fifo_count [CORE_COUNT];
    logic [CORE_COUNT-1:0] fifo_valid;
    logic [CORE_COUNT-1:0] ins_ok, fifo_pop;
    logic [CORE_COUNT-1:0] err_q, err_d;
    logic [SLOT_WIDTH-1:0] sel_head, ic_head;
    logic                  tag_ok;

    assign tag_ok = tag_in_range(32'(slot_ins_tag), SLOT_COUNT);

    always_comb begin
        ins_ok       = '0;
        err_d        = '0;
        fifo_pop     = '0;
        slot_busys   = '0;
        ic_req_ready = 1'b0;
        sel_head     = '0;
        ic_head      = '0;
        for (int c = 0; c < CORE_COUNT; c++) begin
            slot_busys[c] = ic_req_valid && (ic_req_core == CORE_ID_WIDTH'(c));
            if (ic_req_core == CORE_ID_WIDTH'(c)) begin
                ic_req_ready = fifo_valid[c];
                ic_head      = fifo_head[c];
            end
            if (selected_core == CORE_ID_WIDTH'(c))
                sel_head = fifo_head[c];
            // Inter-core port wins; the LB pop on a busy core is simply ignored.
            fifo_pop[c] = (slot_busys[c] && fifo_valid[c]) ||
                          (desc_pop && (selected_core == CORE_ID_WIDTH'(c)) &&
                           fifo_valid[c] && !slot_busys[c]);
            if (slot_ins_valid && (slot_ins_core == CORE_ID_WIDTH'(c)) && !slots_flush[c]) begin
                // Full check uses the pre-cycle count; a concurrent pop does not help.
                ins_ok[c] = enabled_cores[c] && tag_ok && (fifo_count[c] < FULL_CNT);
                err_d[c]  = !ins_ok[c];
            end
        end
    end

    for (genvar c = 0; c < CORE_COUNT; c++) begin : g_fifo
        lb_slot_fifo #(
            .SLOT_COUNT (SLOT_COUNT),
            .SLOT_WIDTH (SLOT_WIDTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (ins_ok[c]),
            .push_tag (slot_ins_tag),
            .pop      (fifo_pop[c]),
            .clear    (slots_flush[c]),
            .head     (fifo_head[c]),
            .count    (fifo_count[c]),
            .valid    (fifo_valid[c])
        );
    end

    always_ff @(posedge clk) begin
        if (rst)
            err_q <= '0;
        else
            err_q <= err_d;
    end

    always_comb begin
        slot_counts = '0;
        for (int c = 0; c < CORE_COUNT; c++)
            slot_counts[c*SLOT_WIDTH +: SLOT_WIDTH] = fifo_count[c];
    end

    assign slot_valids   = fifo_valid;
    assign slot_ins_errs = err_q;
    assign desc_data     = {selected_core, TAG_WIDTH'(sel_head)};
    assign ic_desc_data  = {ic_req_core, TAG_WIDTH'(ic_head)};

endmodule

// File: tb/tb_lb_slot_ctrl.sv
// Directed bench for lb_slot_ctrl with hand-computed expected values
// (8 cores, 32 slots: 6-bit tags, 9-bit descriptors).
module tb_lb_slot_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  enabled_cores;
    logic [7:0]  slots_flush;
    logic        slot_ins_valid;
    logic [2:0]  slot_ins_core;
    logic [5:0]  slot_ins_tag;
    logic [2:0]  selected_core;
    logic        desc_pop;
    logic [8:0]  desc_data;
    logic        ic_req_valid;
    logic [2:0]  ic_req_core;
    logic        ic_req_ready;
    logic [8:0]  ic_desc_data;
    logic [47:0] slot_counts;
    logic [7:0]  slot_valids;
    logic [7:0]  slot_busys;
    logic [7:0]  slot_ins_errs;

    int total = 0;
    int bad   = 0;

    lb_slot_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .enabled_cores  (enabled_cores),
        .slots_flush    (slots_flush),
        .slot_ins_valid (slot_ins_valid),
        .slot_ins_core  (slot_ins_core),
        .slot_ins_tag   (slot_ins_tag),
        .selected_core  (selected_core),
        .desc_pop       (desc_pop),
        .desc_data      (desc_data),
        .ic_req_valid   (ic_req_valid),
        .ic_req_core    (ic_req_core),
        .ic_req_ready   (ic_req_ready),
        .ic_desc_data   (ic_desc_data),
        .slot_counts    (slot_counts),
        .slot_valids    (slot_valids),
        .slot_busys     (slot_busys),
        .slot_ins_errs  (slot_ins_errs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ins(input int core, input int tag);
        slot_ins_valid = 1'b1;
        slot_ins_core  = 3'(core);
        slot_ins_tag   = 6'(tag);
        tick();
        slot_ins_valid = 1'b0;
    endtask

    function automatic logic [5:0] cnt(input int c);
        return slot_counts[c*6 +: 6];
    endfunction

    // Descriptor value {core[2:0], tag[5:0]}
    function automatic logic [63:0] dsc(input int core, input int tag);
        return 64'(core * 64 + tag);
    endfunction

    initial begin
        rst            = 1'b1;
        enabled_cores  = 8'h00;
        slots_flush    = 8'h00;
        slot_ins_valid = 1'b0;
        slot_ins_core  = 3'd0;
        slot_ins_tag   = 6'd0;
        selected_core  = 3'd0;
        desc_pop       = 1'b0;
        ic_req_valid   = 1'b0;
        ic_req_core    = 3'd0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_counts", 64'(slot_counts), 64'd0);
        chk("rst_valids", 64'(slot_valids), 64'd0);
        chk("rst_errs", 64'(slot_ins_errs), 64'd0);
        chk("rst_ready", 64'(ic_req_ready), 64'd0);
        chk("rst_desc", 64'(desc_data), 64'd0);

        enabled_cores = 8'hDF;

        // Insert 1,2,3 on core 3 and pop two via LB
        ins(3, 1);
        chk("ins_lat_cnt3", 64'(cnt(3)), 64'd1);
        ins(3, 2);
        ins(3, 3);
        chk("cnt3_3", 64'(cnt(3)), 64'd3);
        chk("valid3", 64'(slot_valids), 64'h08);
        selected_core = 3'd3;
        desc_pop      = 1'b1;
        #1;
        chk("desc_3_1", 64'(desc_data), dsc(3, 1));
        tick();
        chk("desc_3_2", 64'(desc_data), dsc(3, 2));
        tick();
        desc_pop = 1'b0;
        chk("cnt3_after_pops", 64'(cnt(3)), 64'd1);
        chk("desc_3_3", 64'(desc_data), dsc(3, 3));
        desc_pop = 1'b1;
        tick();
        desc_pop = 1'b0;
        chk("cnt3_empty", 64'(cnt(3)), 64'd0);
        chk("desc_3_empty", 64'(desc_data), dsc(3, 0));
        desc_pop = 1'b1;
        tick();
        desc_pop = 1'b0;
        chk("underflow_cnt3", 64'(cnt(3)), 64'd0);

        // Rejected inserts
        ins(1, 0);
        chk("err_tag0", 64'(slot_ins_errs), 64'h02);
        ins(1, 33);
        chk("err_tag33", 64'(slot_ins_errs), 64'h02);
        ins(5, 4);
        chk("err_disabled", 64'(slot_ins_errs), 64'h20);
        tick();
        chk("err_pulse_end", 64'(slot_ins_errs), 64'h00);
        chk("rej_counts", 64'(slot_counts), 64'd0);

        // Fill core 0, then insert while popping: still full
        for (int i = 1; i <= 32; i++) ins(0, i);
        chk("cnt0_full", 64'(cnt(0)), 64'd32);
        chk("fill_no_err", 64'(slot_ins_errs), 64'h00);
        selected_core  = 3'd0;
        desc_pop       = 1'b1;
        slot_ins_valid = 1'b1;
        slot_ins_core  = 3'd0;
        slot_ins_tag   = 6'd7;
        #1;
        chk("desc_0_1", 64'(desc_data), dsc(0, 1));
        tick();
        desc_pop       = 1'b0;
        slot_ins_valid = 1'b0;
        chk("full_err", 64'(slot_ins_errs), 64'h01);
        chk("cnt0_31", 64'(cnt(0)), 64'd31);
        chk("desc_0_2", 64'(desc_data), dsc(0, 2));
        ins(0, 7);
        chk("wrap_cnt0", 64'(cnt(0)), 64'd32);
        chk("wrap_no_err", 64'(slot_ins_errs), 64'h00);

        // Inter-core request wins over LB pop on the same core
        ins(2, 4);
        ins(2, 9);
        ic_req_valid  = 1'b1;
        ic_req_core   = 3'd2;
        selected_core = 3'd2;
        desc_pop      = 1'b1;
        #1;
        chk("ic_ready", 64'(ic_req_ready), 64'd1);
        chk("ic_desc", 64'(ic_desc_data), dsc(2, 4));
        chk("busy2", 64'(slot_busys), 64'h04);
        tick();
        ic_req_valid = 1'b0;
        desc_pop     = 1'b0;
        chk("cnt2_1", 64'(cnt(2)), 64'd1);
        chk("desc_2_9", 64'(desc_data), dsc(2, 9));
        desc_pop = 1'b1;
        tick();
        desc_pop = 1'b0;
        chk("cnt2_0", 64'(cnt(2)), 64'd0);

        // Simultaneous insert and pop on core 1
        ins(1, 5);
        selected_core  = 3'd1;
        desc_pop       = 1'b1;
        slot_ins_valid = 1'b1;
        slot_ins_core  = 3'd1;
        slot_ins_tag   = 6'd6;
        #1;
        chk("desc_1_5", 64'(desc_data), dsc(1, 5));
        tick();
        desc_pop       = 1'b0;
        slot_ins_valid = 1'b0;
        chk("cnt1_same", 64'(cnt(1)), 64'd1);
        chk("desc_1_6", 64'(desc_data), dsc(1, 6));

        // Concurrent IC pop (core 3) and LB pop (core 1)
        ins(3, 8);
        ic_req_valid = 1'b1;
        ic_req_core  = 3'd3;
        desc_pop     = 1'b1;
        #1;
        chk("ic_desc_3_8", 64'(ic_desc_data), dsc(3, 8));
        tick();
        ic_req_valid = 1'b0;
        desc_pop     = 1'b0;
        chk("conc_cnt1", 64'(cnt(1)), 64'd0);
        chk("conc_cnt3", 64'(cnt(3)), 64'd0);
        chk("ready_empty", 64'(ic_req_ready), 64'd0);

        // Flush core 4 with a same-cycle insert
        for (int i = 1; i <= 10; i++) ins(4, i);
        chk("cnt4_10", 64'(cnt(4)), 64'd10);
        slots_flush    = 8'h10;
        slot_ins_valid = 1'b1;
        slot_ins_core  = 3'd4;
        slot_ins_tag   = 6'd11;
        tick();
        slots_flush    = 8'h00;
        slot_ins_valid = 1'b0;
        chk("flush_cnt4", 64'(cnt(4)), 64'd0);
        chk("flush_valid4", 64'(slot_valids[4]), 64'd0);
        chk("flush_no_err", 64'(slot_ins_errs), 64'h00);
        ins(4, 3);
        selected_core = 3'd4;
        #1;
        chk("post_flush_head", 64'(desc_data), dsc(4, 3));

        // Reset mid-stream
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_counts", 64'(slot_counts), 64'd0);
        chk("mid_rst_valids", 64'(slot_valids), 64'd0);
        chk("mid_rst_desc", 64'(desc_data), dsc(4, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
